// File: rtl/key_entry_pkg.sv
// Shared types for the front-panel key entry block: FSM states, key bit map, decoded events.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package key_entry_pkg;

  // FSM states; the encodings are shown on the panel display.
  typedef enum logic [2:0] {
    S_DIM   = 3'd0,
    S_ELEM  = 3'd1,
    S_READY = 3'd2,
    S_REQ   = 3'd3,
    S_BUSY  = 3'd4
  } state_t;

  // Bit positions of the populated keys in key_in; bits 2 and 6 are unpopulated.
  localparam int NUM_KEYS  = 8;
  localparam int KEY_INC   = 0;
  localparam int KEY_DEC   = 1;
  localparam int KEY_WR    = 3;
  localparam int KEY_CFM   = 4;
  localparam int KEY_START = 5;
  localparam int KEY_ABORT = 7;

  // The single key event the FSM acts on in a given cycle.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_INC   = 3'd1,
    EV_DEC   = 3'd2,
    EV_WR    = 3'd3,
    EV_CFM   = 3'd4,
    EV_START = 3'd5,
    EV_ABORT = 3'd6
  } ev_t;

endpackage

// File: rtl/key_entry_ctrl_if.sv
// Operand-store write port and start/ack/done handshake between the key sequencer and the datapath.
// Latency: wires only.
// Backpressure: start_req is held until start_ack; the write port has no backpressure.
interface key_entry_ctrl_if #(
  parameter int DW = 4,
  parameter int AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start_req;
  logic          start_ack;
  logic          op_done;

  // Sequencer side.
  modport master (
    output wr_en, wr_addr, wr_data, start_req,
    input  start_ack, op_done
  );

  // Operand store / datapath side.
  modport slave (
    input  wr_en, wr_addr, wr_data, start_req,
    output start_ack, op_done
  );
endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchronizer, stable-count debounce, single-cycle press pulse on debounced 1->0.
// Latency: press 3 cycles after the raw edge without KEY_DEBOUNCE_EN, DEBOUNCE_CYC+2 cycles with it.
// Backpressure: none; a press pulse is produced regardless of whether anything consumes it.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk_50M,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  // Without debounce the level follows the synchronizer after a single differing sample,
  // which is the same counter with a window of one.
`ifdef KEY_DEBOUNCE_EN
  localparam int THRESH = DEBOUNCE_CYC;
`else
  localparam int THRESH = 1;
`endif
  localparam int             CW       = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(THRESH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic          sync_q0;
  logic          sync_q1;
  logic          level;
  logic          level_upd;
  logic [CW-1:0] cnt;

  // Level flips on the last sample of an unbroken run of differing samples.
  assign level_upd = (sync_q1 != level) && (cnt == CNT_LAST);

  // Bring the asynchronous key into clk_50M; released (1) out of reset.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync_q0 <= 1'b1;
      sync_q1 <= 1'b1;
    end else begin
      sync_q0 <= key_raw;
      sync_q1 <= sync_q0;
    end
  end

  // Count consecutive cycles the synchronized key disagrees with the level; any bounce restarts it.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((sync_q1 == level) || level_upd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

  // Accept the new level and flag a press only on the released-to-pressed transition.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      press <= level_upd & level;
      if (level_upd) begin
        level <= sync_q1;
      end
    end
  end

endmodule

// File: rtl/key_entry_ctrl.sv
// Front-panel sequencer: debounced keys drive an entry FSM that writes dim/operands and starts the datapath.
// Latency: registered outputs change the cycle after a press event; start_req drops the cycle after start_ack.
// Backpressure: start_req held until start_ack; keys other than abort are ignored while in S_REQ/S_BUSY.
// Build option: define KEY_DEBOUNCE_EN for full debounce; undefined gives a 3-cycle raw-to-event path.
module key_entry_ctrl
  import key_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000,
  parameter int VAL_MAX      = 9,
  parameter int DIM_MAX      = 8,
  parameter int DW           = 4,
  parameter int AW           = 3
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic [NUM_KEYS-1:0]     key_in,
  key_entry_ctrl_if.master        bus,
  output logic [AW:0]             dim_out,
  output logic [AW:0]             elem_cnt,
  output logic [2:0]              state_out,
  output logic                    err
);

  localparam logic [AW:0]   DIM_TOP = (AW+1)'(DIM_MAX);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [DW-1:0] VAL_TOP = DW'(VAL_MAX);
  localparam logic [DW-1:0] VAL_ONE = DW'(1);

  logic [NUM_KEYS-1:0] press;
  logic                unused_keys;
  ev_t                 ev;

  state_t        state, state_nxt;
  logic [AW:0]   dim, dim_nxt;
  logic [AW:0]   idx, idx_nxt;
  logic [DW-1:0] cur_val, cur_val_nxt;
  logic          wr_en_q, wr_en_nxt;
  logic [AW-1:0] wr_addr_q, wr_addr_nxt;
  logic [DW-1:0] wr_data_q, wr_data_nxt;
  logic          start_req_q;
  logic          err_q, err_nxt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_db (
      .clk_50M (clk_50M),
      .rst_n   (rst_n),
      .key_raw (key_in[k]),
      .press   (press[k])
    );
  end

  // Keys 2 and 6 are unpopulated on the board; their presses are deliberately dropped.
  assign unused_keys = press[2] ^ press[6];

  // Keep only the highest-priority press of the cycle: abort > start > confirm > write > dec > inc.
  always_comb begin
    ev = EV_NONE;
    if      (press[KEY_ABORT]) ev = EV_ABORT;
    else if (press[KEY_START]) ev = EV_START;
    else if (press[KEY_CFM])   ev = EV_CFM;
    else if (press[KEY_WR])    ev = EV_WR;
    else if (press[KEY_DEC])   ev = EV_DEC;
    else if (press[KEY_INC])   ev = EV_INC;
  end

  // Entry FSM next state, dimension/index/value updates, write strobe and error pulse.
  always_comb begin
    state_nxt   = state;
    dim_nxt     = dim;
    idx_nxt     = idx;
    cur_val_nxt = cur_val;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    err_nxt     = 1'b0;

    if (ev == EV_ABORT) begin
      state_nxt   = S_DIM;
      dim_nxt     = '0;
      idx_nxt     = '0;
      cur_val_nxt = '0;
    end else begin
      case (state)
        S_DIM: begin
          case (ev)
            EV_INC: dim_nxt = (dim == DIM_TOP) ? '0 : dim + CNT_ONE;
            EV_DEC: dim_nxt = (dim == '0) ? DIM_TOP : dim - CNT_ONE;
            EV_CFM: begin
              if (dim == '0) begin
                err_nxt = 1'b1;
              end else begin
                state_nxt   = S_ELEM;
                idx_nxt     = '0;
                cur_val_nxt = '0;
              end
            end
            EV_WR, EV_START: err_nxt = 1'b1;
            default: ;
          endcase
        end
        S_ELEM: begin
          case (ev)
            EV_INC: cur_val_nxt = (cur_val == VAL_TOP) ? '0 : cur_val + VAL_ONE;
            EV_DEC: cur_val_nxt = (cur_val == '0) ? VAL_TOP : cur_val - VAL_ONE;
            EV_WR: begin
              // cur_val is kept after a write so runs of equal operands need no re-entry.
              if (idx < dim) begin
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = idx[AW-1:0];
                wr_data_nxt = cur_val;
                idx_nxt     = idx + CNT_ONE;
              end else begin
                err_nxt = 1'b1;
              end
            end
            EV_CFM: begin
              if (idx == '0) err_nxt = 1'b1;
              else           state_nxt = S_READY;
            end
            EV_START: err_nxt = 1'b1;
            default: ;
          endcase
        end
        S_READY: begin
          case (ev)
            EV_START: state_nxt = S_REQ;
            EV_INC, EV_DEC, EV_WR, EV_CFM: err_nxt = 1'b1;
            default: ;
          endcase
        end
        S_REQ: begin
          // An op_done coinciding with the ack is not looked at here and is lost.
          if (bus.start_ack) state_nxt = S_BUSY;
        end
        S_BUSY: begin
          if (bus.op_done) begin
            state_nxt   = S_DIM;
            dim_nxt     = '0;
            idx_nxt     = '0;
            cur_val_nxt = '0;
          end
        end
        default: state_nxt = S_DIM;
      endcase
    end
  end

  // State and entry registers.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_DIM;
      dim     <= '0;
      idx     <= '0;
      cur_val <= '0;
    end else begin
      state   <= state_nxt;
      dim     <= dim_nxt;
      idx     <= idx_nxt;
      cur_val <= cur_val_nxt;
    end
  end

  // Registered outputs; start_req tracks S_REQ so it falls with the ack or an abort.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      start_req_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_en_q     <= wr_en_nxt;
      wr_addr_q   <= wr_addr_nxt;
      wr_data_q   <= wr_data_nxt;
      start_req_q <= (state_nxt == S_REQ);
      err_q       <= err_nxt;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.start_req = start_req_q;
  assign dim_out       = dim;
  assign elem_cnt      = idx;
  assign state_out     = state;
  assign err           = err_q;

endmodule

// File: doc/key_entry_ctrl.md
Name: key_entry_ctrl

Overview:
- Front-panel sequencer for the 8-key board input.
- Debounces the active-low keys and turns presses into single-cycle events.
- Runs an entry FSM that collects a dimension and a list of operand values into a downstream operand store, then issues a start/ack handshake to the compute datapath and waits for it to finish.

Parameters:
- DEBOUNCE_CYC, 1000: consecutive stable cycles needed to accept a key level (20 us at 50 MHz).
- VAL_MAX, 9: maximum operand value; value range is 0..VAL_MAX.
- DIM_MAX, 8: maximum element count.
- DW, 4: operand data width; must satisfy 2^DW > VAL_MAX.
- AW, 3: write-address width; must satisfy 2^AW >= DIM_MAX.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- key_in  in  8  raw keys, active-low, asynchronous. Bit map: 0 inc, 1 dec, 3 write, 4 confirm, 5 start, 7 abort; bits 2 and 6 are unused.
- wr_en  out  1  one-cycle write strobe to the operand store.
- wr_addr  out  AW  element index for the write.
- wr_data  out  DW  element value for the write.
- dim_out  out  AW+1  committed dimension.
- elem_cnt  out  AW+1  number of elements written so far.
- start_req  out  1  request to the datapath.
- start_ack  in  1  datapath accepts the request.
- op_done  in  1  one-cycle pulse from the datapath when it finishes.
- state_out  out  3  current FSM state, for display.
- err  out  1  one-cycle pulse on an illegal key action.

Behaviour:
- Reset: all outputs are 0; state is S_DIM; dim, cur_val and idx are 0; every debounced key level is 1 (released).
- Input conditioning, per key:
  - 2-flop synchronizer into clk_50M.
  - The debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the counter.
  - A press event is the debounced 1->0 transition, one cycle wide. Releases generate no event.
- Event priority: at most one event is acted on per cycle, in the order 7 > 5 > 4 > 3 > 1 > 0. Lower-priority events in the same cycle are dropped.
- Latency: every registered output reacts in the cycle after the press-event cycle.
- State encoding: S_DIM=0, S_ELEM=1, S_READY=2, S_REQ=3, S_BUSY=4.
- S_DIM:
  - inc: dim+1, wrapping DIM_MAX->0.
  - dec: dim-1, wrapping 0->DIM_MAX.
  - confirm: if dim==0, pulse err and stay. Otherwise go to S_ELEM with idx=0 and cur_val=0.
  - Any other key: err.
- S_ELEM:
  - inc/dec: cur_val wraps within 0..VAL_MAX.
  - write: if idx<dim, pulse wr_en for one cycle with wr_addr=idx and wr_data=cur_val, then idx+1. cur_val is kept, not cleared. If idx==dim, pulse err and do not write.
  - confirm: if idx==0, pulse err. Otherwise go to S_READY.
  - start: err.
- S_READY:
  - start: go to S_REQ.
  - Any other key except abort: err.
- S_REQ:
  - start_req is held at 1. It drops in the cycle after start_ack is sampled high, and the FSM moves to S_BUSY.
  - start_ack is ignored in every other state.
- S_BUSY:
  - On op_done, go to S_DIM with dim, idx and cur_val cleared.
  - If op_done and start_ack arrive together in S_REQ, the ack is taken first. The op_done is lost; the datapath must not do this.
- Keys in S_REQ/S_BUSY: all keys except abort are ignored, with no err.
- Abort (key 7), any state:
  - Go to S_DIM and clear dim, idx and cur_val.
  - start_req drops in the next cycle.
  - No wr_en is issued in the abort cycle.
  - Aborting from S_BUSY does not wait for op_done; a later op_done in S_DIM is ignored.
- elem_cnt mirrors idx; dim_out mirrors dim.
- Mid-operation reset: async rst_n low returns everything to the reset values immediately, including debounce counters.

Optional Feature:
- KEY_DEBOUNCE_EN defined: debounce as specified above.
- KEY_DEBOUNCE_EN undefined: the debounced level equals the synchronized level directly, so a press event appears 3 cycles after the raw edge (fast simulation). The FSM is unchanged.

Decomposition:
- Package key_entry_pkg:
  - state enum and its encodings;
  - key bit indices (KEY_INC=0, KEY_DEC=1, KEY_WR=3, KEY_CFM=4, KEY_START=5, KEY_ABORT=7).
- Sub-module key_debounce:
  - one instance per key;
  - parameter DEBOUNCE_CYC;
  - synchronizer, stable-count debounce and press pulse;
  - honours KEY_DEBOUNCE_EN.
- The FSM and datapath registers stay in key_entry_ctrl.

Test Plan:
- Reset and defaults: no keys pressed → state_out=0, all outputs 0. Each key held 1500 cycles and released 1500 cycles → exactly one event per press. A 500-cycle glitch → no event.
- Happy path:
  - key0 pressed 3 times, then key4 → dim_out=3, state_out=1.
  - Then key0×2, key3, key0, key3, key0, key3 → wr_en pulses with (addr,data) = (0,2), (1,3), (2,4); elem_cnt=3.
  - A further key0 then key3 → err, no wr_en.
  - key4 → state_out=2.
  - key5 → start_req=1; start_ack after 10 cycles → start_req=0 on the next cycle and state_out=4.
  - op_done → state_out=0 and dim_out=0.
- Wrap: in S_ELEM, key1 from cur_val=0 → 9; key0 from 9 → 0. In S_DIM, key0×9 from 0 → dim_out=0.
- Error cases: key4 with dim 0 → err, state stays 0. key4 in S_ELEM with elem_cnt 0 → err. key5 in S_ELEM → err.
- Priority and abort: key3 and key7 pressed in the same cycle during S_ELEM → no wr_en, state_out=0. key7 during S_REQ → start_req=0 on the next cycle.
- Reset mid-operation: rst_n pulsed low during S_BUSY → all outputs 0 asynchronously; a later op_done has no effect.
